dmem_arb: RTL and testbench

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/dmem_arb.sv | 80 ++++++++
 tb/tb_dmem_arb.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/dmem_arb.sv
// Arbitrates a single-port data memory between the processor and a DMA/loader port.
// The CPU wins conflicts until the DMA has lost STARVE_MAX cycles in a row.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [AW-1:0] i_cpu_wd,
    output logic [AW-1:0] o_cpu_rd,
    output logic          o_cpu_stall,
    input  logic          i_dma_valid,
    input  logic          i_dma_we,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [AW-1:0] i_dma_wd,
    output logic          o_dma_ready,
    output logic          o_dma_rvalid,
    output logic [AW-1:0] o_dma_rdata,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_a,
    output logic [AW-1:0] o_mem_wd,
    input  logic [AW-1:0] i_mem_rd,
    output logic          o_owner
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]    r_starve_cnt;
    logic          r_dma_rvalid;
    logic [AW-1:0] r_dma_rdata;
    owner_e        r_owner;
    logic          w_dma_grant;
    logic          w_starved;

    assign w_starved   = (r_starve_cnt == SMAX);
    assign w_dma_grant = i_dma_valid & ~rst & (~i_cpu_req | w_starved);

    assign o_dma_ready = w_dma_grant;
    assign o_cpu_stall = w_dma_grant & i_cpu_req;
    assign o_cpu_rd    = i_mem_rd;

    // Reset gates the CPU write strobe; the DMA side is already gated through the grant.
    assign o_mem_we = w_dma_grant ? i_dma_we   : (i_cpu_req & i_cpu_we & ~rst);
    assign o_mem_a  = w_dma_grant ? i_dma_addr : i_cpu_addr;
    assign o_mem_wd = w_dma_grant ? i_dma_wd   : i_cpu_wd;

    // Withdrawing the DMA request forfeits any accumulated starvation credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (w_dma_grant || !i_dma_valid) begin
            r_starve_cnt <= 4'd0;
        end else if (i_cpu_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
            r_owner      <= OWN_CPU;
        end else begin
            r_dma_rvalid <= w_dma_grant & ~i_dma_we;
            r_owner      <= w_dma_grant ? OWN_DMA : OWN_CPU;
            if (w_dma_grant && !i_dma_we)
                r_dma_rdata <= i_mem_rd;
        end
    end

    assign o_dma_rvalid = r_dma_rvalid;
    assign o_dma_rdata  = r_dma_rdata;
    assign o_owner      = r_owner;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: a behavioural memory, directed scenarios,
// and a scoreboard of expected DMA read data checked as responses appear.
module tb_dmem_arb;

    logic        clk, rst;
    logic        cpu_req, cpu_we, dma_valid, dma_we;
    logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd;
    logic [31:0] cpu_rd, dma_rdata, mem_a, mem_wd, mem_rd;
    logic        cpu_stall, dma_ready, dma_rvalid, mem_we, owner;

    logic [31:0] mem [0:255];
    logic [31:0] sb [$];
    int n_tests = 0;
    int n_fail  = 0;

    dmem_arb #(.STARVE_MAX(4), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wd(cpu_wd),
        .o_cpu_rd(cpu_rd), .o_cpu_stall(cpu_stall),
        .i_dma_valid(dma_valid), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wd(dma_wd),
        .o_dma_ready(dma_ready), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
        .o_mem_we(mem_we), .o_mem_a(mem_a), .o_mem_wd(mem_wd), .i_mem_rd(mem_rd),
        .o_owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dma_rvalid) begin
            if (sb.size() == 0) chk("rv_spurious", 32'(dma_rvalid), 32'd0);
            else chk("rv_data", dma_rdata, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
        dma_valid = 0; dma_we = 0; dma_addr = 0; dma_wd = 0;
    endtask

    task automatic cpu(input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wd = d;
    endtask

    task automatic dma(input logic we, input logic [31:0] a, input logic [31:0] d);
        dma_valid = 1; dma_we = we; dma_addr = a; dma_wd = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        idle();
        rst = 1;
        cpu(1, 32'h10, 32'hDEAD);
        dma(0, 32'h10, 0);
        tick();
        @(negedge clk);
        chk("rst_ready",  32'(dma_ready), 0);
        chk("rst_stall",  32'(cpu_stall), 0);
        chk("rst_memwe",  32'(mem_we), 0);
        chk("rst_rvalid", 32'(dma_rvalid), 0);
        chk("rst_rdata",  dma_rdata, 0);
        chk("rst_owner",  32'(owner), 0);
        tick();
        rst = 0; idle();
        tick();

        // CPU only: store then load
        cpu(1, 32'h10, 32'hAB);
        @(negedge clk);
        chk("cpu_st_stall", 32'(cpu_stall), 0);
        chk("cpu_st_ready", 32'(dma_ready), 0);
        chk("cpu_st_memwe", 32'(mem_we), 1);
        tick();
        cpu(0, 32'h10, 0);
        @(negedge clk);
        chk("cpu_ld_rd",    cpu_rd, 32'hAB);
        chk("cpu_ld_stall", 32'(cpu_stall), 0);
        chk("cpu_ld_memwe", 32'(mem_we), 0);
        tick();

        // DMA only: write then read, response one cycle later
        idle(); dma(1, 32'h20, 32'h1234);
        @(negedge clk);
        chk("dma_wr_ready", 32'(dma_ready), 1);
        chk("dma_wr_memwe", 32'(mem_we), 1);
        chk("dma_wr_addr",  mem_a, 32'h20);
        tick();
        dma(0, 32'h20, 0);
        @(negedge clk);
        chk("dma_rd_ready",  32'(dma_ready), 1);
        chk("dma_rd_rvalid", 32'(dma_rvalid), 0);
        sb.push_back(32'h1234);
        tick();
        idle();
        @(negedge clk);
        chk("dma_rsp_rvalid", 32'(dma_rvalid), 1);
        chk("dma_rsp_owner",  32'(owner), 1);
        tick();
        @(negedge clk);
        chk("dma_rsp_pulse", 32'(dma_rvalid), 0);
        chk("dma_rsp_hold",  dma_rdata, 32'h1234);
        tick();

        // Back-to-back DMA reads
        dma(0, 32'h10, 0);
        @(negedge clk); chk("b2b_rdy0", 32'(dma_ready), 1); sb.push_back(32'hAB);
        tick();
        dma(0, 32'h20, 0);
        @(negedge clk); chk("b2b_rdy1", 32'(dma_ready), 1); sb.push_back(32'h1234);
        tick();
        idle();
        @(negedge clk); chk("b2b_rv1", 32'(dma_rvalid), 1);
        tick(); tick();

        // Continuous conflict: DMA forced through every fifth cycle
        for (int k = 0; k < 15; k++) begin
            cpu(0, 32'h40, 0); dma(0, 32'h10, 0);
            @(negedge clk);
            chk("conf_ready", 32'(dma_ready), 32'(k % 5 == 4));
            chk("conf_stall", 32'(cpu_stall), 32'(k % 5 == 4));
            chk("conf_owner", 32'(owner), 32'(k > 0 && k % 5 == 0));
            if (k % 5 == 4) sb.push_back(32'hAB);
            tick();
        end
        idle(); tick(); tick();

        // Dropping DMA valid clears the starvation count
        for (int k = 0; k < 8; k++) begin
            cpu(0, 32'h40, 0);
            if (k == 2) begin dma_valid = 0; dma_we = 0; end
            else dma(1, 32'h50, 32'h77);
            @(negedge clk);
            chk("starve_ready", 32'(dma_ready), 32'(k == 7));
            tick();
        end
        idle(); tick();

        // Same-address race in the forced-DMA cycle: retried CPU store lands last
        for (int k = 0; k < 4; k++) begin
            cpu(0, 32'h30, 0); dma(1, 32'h30, 32'h55);
            @(negedge clk); chk("race_pre_ready", 32'(dma_ready), 0);
            tick();
        end
        cpu(1, 32'h30, 32'hAA); dma(1, 32'h30, 32'h55);
        @(negedge clk);
        chk("race_ready", 32'(dma_ready), 1);
        chk("race_stall", 32'(cpu_stall), 1);
        chk("race_wd",    mem_wd, 32'h55);
        tick();
        idle(); cpu(1, 32'h30, 32'hAA);
        @(negedge clk);
        chk("race_retry_stall", 32'(cpu_stall), 0);
        chk("race_mid_rd",      cpu_rd, 32'h55);
        tick();
        cpu(0, 32'h30, 0);
        @(negedge clk); chk("race_final", cpu_rd, 32'hAA);
        tick();

        // Reset asserted in a DMA read accept cycle
        idle(); tick();
        rst = 1; dma(0, 32'h10, 0); cpu(1, 32'h60, 32'h99);
        @(negedge clk);
        chk("rstrd_ready",  32'(dma_ready), 0);
        chk("rstrd_memwe",  32'(mem_we), 0);
        chk("rstrd_stall",  32'(cpu_stall), 0);
        chk("rstrd_owner",  32'(owner), 0);
        chk("rstrd_rdata",  dma_rdata, 0);
        tick();
        @(negedge clk); chk("rstrd_rvalid0", 32'(dma_rvalid), 0);
        tick();
        rst = 0; idle();
        @(negedge clk); chk("rstrd_rvalid1", 32'(dma_rvalid), 0);
        tick();
        cpu(0, 32'h60, 0);
        @(negedge clk);
        chk("rstrd_rvalid2", 32'(dma_rvalid), 0);
        chk("rstrd_nowrite", cpu_rd, 0);
        chk("rstrd_owner2",  32'(owner), 0);
        tick();
        idle(); tick();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
